// File: rtl/axi_cdma_desc_mux_credit.sv
// Descriptor mux in front of a CDMA core: arbitrates per-port descriptor streams,
// tags each with its source port and limits in-flight descriptors per port.
module axi_cdma_desc_mux_credit #(
    parameter int PORTS           = 4,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 20,
    parameter int S_TAG_WIDTH     = 8,
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + ((PORTS > 1) ? $clog2(PORTS) : 1),
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARB_ROUND_ROBIN = 1,
    localparam int CL = (PORTS > 1) ? $clog2(PORTS) : 1,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [AXI_ADDR_WIDTH-1:0]         m_axis_desc_read_addr,
    output logic [AXI_ADDR_WIDTH-1:0]         m_axis_desc_write_addr,
    output logic [LEN_WIDTH-1:0]              m_axis_desc_len,
    output logic [M_TAG_WIDTH-1:0]            m_axis_desc_tag,
    output logic                              m_axis_desc_valid,
    input  logic                              m_axis_desc_ready,
    input  logic [M_TAG_WIDTH-1:0]            s_axis_desc_status_tag,
    input  logic [3:0]                        s_axis_desc_status_error,
    input  logic                              s_axis_desc_status_valid,
    input  logic [PORTS*AXI_ADDR_WIDTH-1:0]   s_axis_desc_read_addr,
    input  logic [PORTS*AXI_ADDR_WIDTH-1:0]   s_axis_desc_write_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]        s_axis_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]      s_axis_desc_tag,
    input  logic [PORTS-1:0]                  s_axis_desc_valid,
    output logic [PORTS-1:0]                  s_axis_desc_ready,
    output logic [PORTS*S_TAG_WIDTH-1:0]      m_axis_desc_status_tag,
    output logic [PORTS*4-1:0]                m_axis_desc_status_error,
    output logic [PORTS-1:0]                  m_axis_desc_status_valid,
    input  logic [PORTS-1:0]                  port_enable,
    output logic [PORTS*CW-1:0]               port_outstanding
);

    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = 2 * AW + LEN_WIDTH + M_TAG_WIDTH;
    localparam int PW = CL + 1;

    generate
        if (M_TAG_WIDTH < S_TAG_WIDTH + CL) begin : g_bad_tag
            $error("M_TAG_WIDTH cannot hold source tag plus port index");
        end
        if (MAX_OUTSTANDING < 1) begin : g_bad_max
            $error("MAX_OUTSTANDING must be at least 1");
        end
    endgenerate

    logic [CW-1:0]          cnt [PORTS];
    logic [CL-1:0]          rr_ptr;
    logic                   int_ready;
    logic                   m_valid;
    logic                   t_valid;
    logic [DW-1:0]          m_data;
    logic [DW-1:0]          t_data;
    logic [PORTS-1:0]       stat_valid;
    logic [S_TAG_WIDTH-1:0] stat_tag;
    logic [3:0]             stat_err;

    logic [PORTS-1:0]       elig;
    logic [CL-1:0]          sel;
    logic                   sel_ok;
    logic [PW-1:0]          idx;
    logic                   accept;
    logic                   early;
    logic [DW-1:0]          in_data;
    logic [CL-1:0]          st_port;
    logic                   st_ok;
    logic                   unused_tag_bits;

    // Eligibility uses registered counts only, so credits never form a comb loop
    always_comb begin
        elig = '0;
        for (int i = 0; i < PORTS; i++) begin
            elig[i] = s_axis_desc_valid[i] && port_enable[i]
                   && (cnt[i] < CW'(MAX_OUTSTANDING));
        end
    end

    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        idx    = '0;
        for (int k = 0; k < PORTS; k++) begin
            idx = (ARB_ROUND_ROBIN != 0) ? ({1'b0, rr_ptr} + PW'(k)) : PW'(k);
            if (idx >= PW'(PORTS)) begin
                idx = idx - PW'(PORTS);
            end
            if (!sel_ok && elig[idx[CL-1:0]]) begin
                sel    = idx[CL-1:0];
                sel_ok = 1'b1;
            end
        end
    end

    assign accept = int_ready && sel_ok;
    assign s_axis_desc_ready = accept ? (PORTS'(1) << sel) : '0;

    always_comb begin
        in_data = {s_axis_desc_read_addr[sel*AW +: AW],
                   s_axis_desc_write_addr[sel*AW +: AW],
                   s_axis_desc_len[sel*LEN_WIDTH +: LEN_WIDTH],
                   M_TAG_WIDTH'({sel, s_axis_desc_tag[sel*S_TAG_WIDTH +: S_TAG_WIDTH]})};
    end

    // Ready for next cycle only if the temp slot cannot be filled by this cycle
    assign early = m_axis_desc_ready || (!t_valid && (!m_valid || !accept));

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid   <= 1'b0;
            t_valid   <= 1'b0;
            int_ready <= 1'b0;
        end else begin
            int_ready <= early;
            if (int_ready) begin
                if (m_axis_desc_ready || !m_valid) begin
                    m_valid <= accept;
                end else begin
                    t_valid <= accept;
                end
            end else if (m_axis_desc_ready) begin
                m_valid <= t_valid;
                t_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (int_ready) begin
            if (m_axis_desc_ready || !m_valid) begin
                m_data <= in_data;
            end else begin
                t_data <= in_data;
            end
        end else if (m_axis_desc_ready) begin
            m_data <= t_data;
        end
        stat_tag <= s_axis_desc_status_tag[S_TAG_WIDTH-1:0];
        stat_err <= s_axis_desc_status_error;
    end

    assign st_port = s_axis_desc_status_tag[S_TAG_WIDTH +: CL];
    assign st_ok   = s_axis_desc_status_valid && ({1'b0, st_port} < PW'(PORTS));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            stat_valid <= '0;
            for (int i = 0; i < PORTS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stat_valid <= st_ok ? (PORTS'(1) << st_port) : '0;
            if (accept) begin
                rr_ptr <= ({1'b0, sel} == PW'(PORTS - 1)) ? '0 : sel + CL'(1);
            end
            for (int i = 0; i < PORTS; i++) begin
                if (accept && sel == CL'(i) && !(st_ok && st_port == CL'(i))) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (st_ok && st_port == CL'(i) && !(accept && sel == CL'(i))
                             && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    assign m_axis_desc_valid        = m_valid;
    assign m_axis_desc_read_addr    = m_data[DW-1 -: AW];
    assign m_axis_desc_write_addr   = m_data[DW-AW-1 -: AW];
    assign m_axis_desc_len          = m_data[M_TAG_WIDTH +: LEN_WIDTH];
    assign m_axis_desc_tag          = m_data[M_TAG_WIDTH-1:0];
    assign m_axis_desc_status_valid = stat_valid;
    assign m_axis_desc_status_tag   = {PORTS{stat_tag}};
    assign m_axis_desc_status_error = {PORTS{stat_err}};
    assign unused_tag_bits          = ^s_axis_desc_status_tag;

    generate
        for (genvar g = 0; g < PORTS; g++) begin : g_cnt
            assign port_outstanding[g*CW +: CW] = cnt[g];
        end
    endgenerate

endmodule

// File: tb/tb_axi_cdma_desc_mux_credit.sv
// Directed bench for axi_cdma_desc_mux_credit: expected descriptors and status
// strobes are queued by the stimulus and consumed by an output monitor.
module tb_axi_cdma_desc_mux_credit;

    localparam int P   = 4;
    localparam int AW  = 16;
    localparam int LW  = 20;
    localparam int STW = 8;
    localparam int MTW = 10;
    localparam int MO  = 2;
    localparam int CW  = 2;
    localparam int DW  = 2 * AW + LW + MTW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0]    m_ra, m_wa;
    logic [LW-1:0]    m_len;
    logic [MTW-1:0]   m_tag;
    logic             m_valid;
    logic             m_ready;
    logic [MTW-1:0]   st_tag;
    logic [3:0]       st_err;
    logic             st_valid;
    logic [P*AW-1:0]  s_ra, s_wa;
    logic [P*LW-1:0]  s_len;
    logic [P*STW-1:0] s_tag;
    logic [P-1:0]     s_valid, s_ready;
    logic [P*STW-1:0] o_stag;
    logic [P*4-1:0]   o_serr;
    logic [P-1:0]     o_sval;
    logic [P-1:0]     en_ports;
    logic [P*CW-1:0]  outst;

    always #5 clk = ~clk;

    axi_cdma_desc_mux_credit #(
        .PORTS(P),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m_axis_desc_read_addr(m_ra),
        .m_axis_desc_write_addr(m_wa),
        .m_axis_desc_len(m_len),
        .m_axis_desc_tag(m_tag),
        .m_axis_desc_valid(m_valid),
        .m_axis_desc_ready(m_ready),
        .s_axis_desc_status_tag(st_tag),
        .s_axis_desc_status_error(st_err),
        .s_axis_desc_status_valid(st_valid),
        .s_axis_desc_read_addr(s_ra),
        .s_axis_desc_write_addr(s_wa),
        .s_axis_desc_len(s_len),
        .s_axis_desc_tag(s_tag),
        .s_axis_desc_valid(s_valid),
        .s_axis_desc_ready(s_ready),
        .m_axis_desc_status_tag(o_stag),
        .m_axis_desc_status_error(o_serr),
        .m_axis_desc_status_valid(o_sval),
        .port_enable(en_ports),
        .port_outstanding(outst)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0]      exp_desc[$];
    logic [P+STW+3:0]   exp_stat[$];
    int n[P];
    int en[P];
    int want[P];
    logic [P-1:0] hs_seen;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Source fields for the k-th descriptor of port p, with the expected tag form
    function automatic logic [DW-1:0] desc_of(int p, int k);
        logic [AW-1:0]  ra;
        logic [AW-1:0]  wa;
        logic [LW-1:0]  ln;
        logic [STW-1:0] t;
        ra = AW'(p * 4096 + k + 1);
        wa = AW'(32768 + p * 256 + k);
        ln = LW'(p * 1000 + k + 7);
        t  = STW'(p * 16 + k);
        return {ra, wa, ln, 2'(p), t};
    endfunction

    function automatic logic [CW-1:0] cnt(int p);
        return outst[p*CW +: CW];
    endfunction

    function automatic bit pending();
        for (int p = 0; p < P; p++) begin
            if (want[p] > 0 && en_ports[p]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic apply();
        logic [DW-1:0] d;
        for (int p = 0; p < P; p++) begin
            d = desc_of(p, n[p]);
            s_ra[p*AW +: AW]    = d[DW-1 -: AW];
            s_wa[p*AW +: AW]    = d[DW-AW-1 -: AW];
            s_len[p*LW +: LW]   = d[MTW +: LW];
            s_tag[p*STW +: STW] = d[STW-1:0];
            s_valid[p]          = (want[p] > 0);
        end
    endtask

    task automatic step();
        logic [P-1:0] hs;
        @(negedge clk);
        hs = s_valid & s_ready;
        hs_seen = hs_seen | hs;
        @(posedge clk);
        #1;
        for (int p = 0; p < P; p++) begin
            if (hs[p]) begin
                n[p]++;
                want[p]--;
            end
        end
        apply();
    endtask

    task automatic push_desc(int p);
        exp_desc.push_back(desc_of(p, en[p]));
        en[p]++;
    endtask

    task automatic send_status(int p, logic [STW-1:0] t, logic [3:0] e);
        st_tag   = {2'(p), t};
        st_err   = e;
        st_valid = 1'b1;
        exp_stat.push_back({4'(1 << p), t, e});
        step();
        st_valid = 1'b0;
    endtask

    task automatic drain(string name);
        int b;
        b = 0;
        while (pending() || exp_desc.size() != 0 || exp_stat.size() != 0) begin
            step();
            b++;
            if (b > 60) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: timeout, %0d desc %0d status still expected",
                         name, exp_desc.size(), exp_stat.size());
                exp_desc.delete();
                exp_stat.delete();
                for (int p = 0; p < P; p++) want[p] = 0;
                apply();
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (m_valid === 1'b1 && m_ready) begin
            if (exp_desc.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL desc_extra: got %h expected nothing", {m_ra, m_wa, m_len, m_tag});
            end else begin
                check("desc_out", 64'({m_ra, m_wa, m_len, m_tag}), 64'(exp_desc.pop_front()));
            end
        end
        if (o_sval !== '0 && !rst) begin
            if (exp_stat.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL status_extra: got %h expected nothing", o_sval);
            end else begin
                check("status_out", 64'({o_sval, o_stag[3*STW +: STW], o_serr[15:12]}),
                      64'(exp_stat.pop_front()));
            end
        end
    end

    initial begin
        m_ready  = 1'b1;
        en_ports = 4'hF;
        st_valid = 1'b0;
        st_tag   = '0;
        st_err   = '0;
        hs_seen  = '0;
        for (int p = 0; p < P; p++) begin
            n[p] = 0;
            en[p] = 0;
            want[p] = 0;
        end
        apply();
        step();
        step();
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_st_valid", 64'(o_sval), 64'(0));
        check("rst_counts", 64'(outst), 64'(0));
        rst = 1'b0;
        step();

        // Round-robin across all ports
        push_desc(0); push_desc(1); push_desc(2); push_desc(3); push_desc(0);
        want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
        apply();
        drain("rr_stream");
        check("rr_counts", 64'(outst), 64'(8'b01_01_01_10));
        send_status(0, 8'h10, 4'h1);
        send_status(0, 8'h11, 4'h2);
        send_status(1, 8'h12, 4'h3);
        send_status(2, 8'h13, 4'h4);
        send_status(3, 8'h14, 4'h5);
        drain("rr_status");
        check("rr_counts_zero", 64'(outst), 64'(0));

        // Credit limit on port 1
        push_desc(1); push_desc(1);
        want[1] = 3;
        apply();
        repeat (6) step();
        check("cr_remaining", 64'(want[1]), 64'(1));
        check("cr_ready_low", 64'(s_ready), 64'(0));
        check("cr_count", 64'(cnt(1)), 64'(2));
        check("cr_drained", 64'(exp_desc.size()), 64'(0));
        push_desc(1);
        send_status(1, 8'h20, 4'h6);
        drain("cr_third");
        check("cr_count_after", 64'(cnt(1)), 64'(2));
        send_status(1, 8'h21, 4'h7);
        send_status(1, 8'h22, 4'h8);
        drain("cr_status");
        check("cr_counts_zero", 64'(outst), 64'(0));

        // Output stall: skid buffer absorbs exactly two
        m_ready = 1'b0;
        push_desc(0); push_desc(0); push_desc(0); push_desc(0);
        want[0] = 4;
        apply();
        repeat (5) step();
        check("stall_accepted", 64'(want[0]), 64'(2));
        check("stall_m_valid", 64'(m_valid), 64'(1));
        send_status(0, 8'h30, 4'h9);
        send_status(0, 8'h31, 4'hA);
        check("stall_count", 64'(cnt(0)), 64'(0));
        check("stall_ready_low", 64'(s_ready), 64'(0));
        check("stall_still_two", 64'(want[0]), 64'(2));
        check("stall_hold", 64'({m_ra, m_wa, m_len, m_tag}), 64'(exp_desc[0]));
        m_ready = 1'b1;
        drain("stall_release");
        check("stall_count_after", 64'(cnt(0)), 64'(2));
        send_status(0, 8'h32, 4'hB);
        send_status(0, 8'h33, 4'hC);
        drain("stall_status");

        // Same-cycle increment and decrement on port 2
        push_desc(2);
        want[2] = 1;
        apply();
        drain("same_setup");
        check("same_pre_count", 64'(cnt(2)), 64'(1));
        push_desc(2);
        want[2] = 1;
        apply();
        st_tag   = {2'd2, 8'h42};
        st_err   = 4'hD;
        st_valid = 1'b1;
        exp_stat.push_back({4'b0100, 8'h42, 4'hD});
        step();
        st_valid = 1'b0;
        check("same_accepted", 64'(want[2]), 64'(0));
        check("same_count", 64'(cnt(2)), 64'(1));
        check("same_st_valid", 64'(o_sval), 64'(4'b0100));
        check("same_st_err", 64'(o_serr[11:8]), 64'(4'hD));
        drain("same_drain");
        send_status(2, 8'h43, 4'hE);
        drain("same_status");
        check("same_counts_zero", 64'(outst), 64'(0));

        // Port 1 disabled; pointer sits at port 3
        en_ports = 4'b1101;
        hs_seen  = '0;
        push_desc(3); push_desc(0); push_desc(2);
        want[0] = 1; want[1] = 1; want[2] = 1; want[3] = 1;
        apply();
        drain("en_stream");
        check("en_port1_grant", 64'(hs_seen[1]), 64'(0));
        check("en_port1_left", 64'(want[1]), 64'(1));
        check("en_counts", 64'(outst), 64'(8'b01_01_00_01));

        // Reset while descriptors sit in the output buffer
        m_ready  = 1'b0;
        en_ports = 4'hF;
        want[0]  = 1;
        apply();
        step();
        step();
        rst = 1'b1;
        for (int p = 0; p < P; p++) want[p] = 0;
        apply();
        step();
        check("rst_mid_m_valid", 64'(m_valid), 64'(0));
        check("rst_mid_counts", 64'(outst), 64'(0));
        check("rst_mid_s_ready", 64'(s_ready), 64'(0));
        rst = 1'b0;
        m_ready = 1'b1;
        for (int p = 0; p < P; p++) en[p] = n[p];
        step();
        push_desc(0); push_desc(2);
        want[0] = 1; want[2] = 1;
        apply();
        drain("post_rst");
        check("post_rst_counts", 64'(outst), 64'(8'b00_01_00_01));
        check("queues_empty", 64'(exp_desc.size() + exp_stat.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
